sar_cycle_ctrl: RTL and testbench
=================================

SAR_CYCLE_CTRL -- requirements
Module: sar_cycle_ctrl

Interface
REQ-001 Parameter N, default 8: conversion resolution (number of decision cycles), 2..16.
REQ-002 Parameter CF_MODE, default 0: cycle-flag encoding; 0 thermometer, 1 one-hot.
REQ-003 Parameter SYNC_STAGES, default 2: synchroniser depth on RDY, CKS and COMP, 2..4.
REQ-004 Parameter TIMEOUT, default 255: max CLK cycles between decisions before fault, 1..65535.
REQ-005 CLK  in  1  system clock; all state changes on its rising edge; one clock domain.
REQ-006 RST  in  1  reset, synchronous, active-high.
REQ-007 CKS  in  1  sample clock, asynchronous; high = convert window, low = sample/clear.
REQ-008 RDY  in  1  comparator-ready strobe, asynchronous; each rising edge = one decision.
REQ-009 COMP in  1  comparator decision; stable 1 CLK before RDY rise to SYNC_STAGES+1 CLK after.
REQ-010 CF   out N  cycle flags, encoding per CF_MODE.
REQ-011 DOUT out N  conversion result, MSB decided first.
REQ-012 FINAL out 1  high once all N decisions are taken; held until CKS low.
REQ-013 VALID out 1  one-CLK pulse in the cycle FINAL rises.
REQ-014 BUSY out 1  high while conversion in progress.
REQ-015 ERR  out 1  sticky timeout flag.

Function
REQ-016 RDY, CKS and COMP SHALL pass through identical SYNC_STAGES-flop synchronisers; RDY and CKS edges are detected on synchronised outputs against a one-flop history.
REQ-017 States SHALL be IDLE, CONV, DONE, FAULT.
REQ-018 IDLE: on synchronised CKS rising edge -> CONV, clearing CF, DOUT, ERR, bit counter and timeout counter in the same edge.
REQ-019 CONV: on RDY event k (1..N), DOUT[N-k] <= synchronised COMP; CF updates on the same edge.
REQ-020 Latency: CF/DOUT update on CLK edge SYNC_STAGES+1, counting the first edge sampling RDY=1 as edge 1.
REQ-021 CF_MODE 0: after k events CF[N-1:N-k] = all ones, rest zero; CF_MODE 1: only CF[N-k] high; k=0 -> CF=0 in both modes.
REQ-022 On event N: -> DONE, FINAL=1, VALID pulses for exactly one cycle.
REQ-023 DONE: further RDY events ignored; CF, DOUT, FINAL hold; on CKS low -> IDLE.
REQ-024 Timeout counter SHALL reset on entry to CONV and on each RDY event; on reaching TIMEOUT -> FAULT with ERR=1.
REQ-025 FAULT: FINAL=0, no VALID, CF and DOUT hold partial values; on CKS low -> IDLE; ERR stays set until next conversion start or RST.
REQ-026 CKS low in CONV (abort): -> IDLE, CF=0, FINAL=0, no VALID, DOUT holds partial value.
REQ-027 CKS low and RDY event in the same cycle: abort wins; event discarded.
REQ-028 In IDLE, CF=0 and FINAL=0; RDY events are ignored.
REQ-029 BUSY SHALL equal (state == CONV), registered.

Reset
REQ-030 RST high SHALL, on the next CLK edge, force state IDLE and CF=0, DOUT=0, FINAL=0, VALID=0, BUSY=0, ERR=0, clear all synchroniser and history flops and all counters.
REQ-031 RST SHALL override every other input, including mid-conversion; no VALID is produced for an interrupted conversion.

Structure
REQ-032 Package sar_pkg SHALL hold the state enumeration and CF_MODE encoding constants (CF_THERMO=0, CF_ONEHOT=1).
REQ-033 Sub-module sar_sync (parametrised-depth single-bit synchroniser with synchronous reset) SHALL be instantiated three times.

Verification (N=8, SYNC_STAGES=2 unless stated)
REQ-034 CKS high, 8 RDY pulses, COMP 1,0,1,1,0,0,1,0 -> DOUT=8'hB2, CF=8'hFF, FINAL=1, one VALID pulse, BUSY=0.
REQ-035 CF_MODE=1, 3 RDY pulses -> CF=8'h20, BUSY=1, FINAL=0.
REQ-036 CKS low after 4 pulses -> CF=0, FINAL=0, no VALID, IDLE; next CKS rise clears DOUT.
REQ-037 TIMEOUT=16, CKS high, no RDY -> ERR=1 16 cycles after CONV entry, BUSY=0, FINAL=0.
REQ-038 9th RDY pulse in DONE -> DOUT, CF, FINAL unchanged, no second VALID.
REQ-039 RST pulsed for 1 cycle after 5 pulses -> all outputs 0 on the next edge; subsequent full conversion correct.

Source files
------------

// File: rtl/sar_pkg.sv
// Shared types and constants for the SAR conversion cycle controller.
package sar_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CONV  = 2'd1,
      ST_DONE  = 2'd2,
      ST_FAULT = 2'd3
   } sar_state_t;

   localparam int CF_THERMO = 0;
   localparam int CF_ONEHOT = 1;

   localparam int TMO_W = 16;

endpackage

// File: rtl/sar_sync.sv
// Single-bit synchroniser of parametrised depth with synchronous clear.
module sar_sync #(
   parameter int DEPTH = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [DEPTH-1:0] stg;

   always_ff @(posedge clk) begin
      if (rst) stg <= '0;
      else     stg <= {stg[DEPTH-2:0], d};
   end

   assign q = stg[DEPTH-1];

endmodule

// File: rtl/sar_cycle_ctrl.sv
// SAR conversion sequencer: counts comparator-ready strobes inside a CKS window,
// assembles the result MSB-first and flags completion, abort and timeout.
//
// state    | meaning
// ST_IDLE  | waiting for CKS rise; CF and FINAL held at zero
// ST_CONV  | collecting decisions, timeout timer running
// ST_DONE  | all N decisions taken; results frozen until CKS low
// ST_FAULT | decision gap exceeded TIMEOUT; partial result frozen, ERR set
module sar_cycle_ctrl
   import sar_pkg::*;
#(
   parameter int N           = 8,
   parameter int CF_MODE     = 0,
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT     = 255
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         CKS,
   input  logic         RDY,
   input  logic         COMP,
   output logic [N-1:0] CF,
   output logic [N-1:0] DOUT,
   output logic         FINAL,
   output logic         VALID,
   output logic         BUSY,
   output logic         ERR
);

   localparam int CW = $clog2(N + 1);

   logic rdy_s, cks_s, comp_s;
   logic rdy_h, cks_h;
   logic rdy_evt, cks_rise;

   sar_state_t        state_q, state_n;
   logic [CW-1:0]     cnt_q, cnt_n;
   logic [TMO_W-1:0]  tmo_q, tmo_n;
   logic [N-1:0]      cf_q, cf_n, dout_q, dout_n;
   logic              final_q, final_n, valid_q, valid_n, err_q, err_n, busy_q;

   sar_sync #(.DEPTH(SYNC_STAGES)) u_sync_rdy  (.clk(CLK), .rst(RST), .d(RDY),  .q(rdy_s));
   sar_sync #(.DEPTH(SYNC_STAGES)) u_sync_cks  (.clk(CLK), .rst(RST), .d(CKS),  .q(cks_s));
   sar_sync #(.DEPTH(SYNC_STAGES)) u_sync_comp (.clk(CLK), .rst(RST), .d(COMP), .q(comp_s));

   assign rdy_evt  = rdy_s & ~rdy_h;
   assign cks_rise = cks_s & ~cks_h;

   always_comb begin
      state_n = state_q;
      cnt_n   = cnt_q;
      tmo_n   = tmo_q;
      cf_n    = cf_q;
      dout_n  = dout_q;
      final_n = final_q;
      valid_n = 1'b0;
      err_n   = err_q;

      case (state_q)
         ST_IDLE: begin
            cf_n    = '0;
            final_n = 1'b0;
            if (cks_rise) begin
               state_n = ST_CONV;
               dout_n  = '0;
               err_n   = 1'b0;
               cnt_n   = '0;
               tmo_n   = TMO_W'(TIMEOUT);
            end
         end
         ST_CONV: begin
            // Abort takes priority over a decision arriving in the same cycle.
            if (!cks_s) begin
               state_n = ST_IDLE;
               cf_n    = '0;
               final_n = 1'b0;
            end else if (rdy_evt) begin
               for (int i = 0; i < N; i++)
                  if (i == N - 1 - int'(cnt_q)) dout_n[i] = comp_s;
               if (CF_MODE == CF_THERMO)
                  cf_n = {1'b1, cf_q[N-1:1]};
               else if (cnt_q == '0)
                  cf_n = {1'b1, {(N-1){1'b0}}};
               else
                  cf_n = cf_q >> 1;
               cnt_n = cnt_q + CW'(1);
               tmo_n = TMO_W'(TIMEOUT);
               if (int'(cnt_q) == N - 1) begin
                  state_n = ST_DONE;
                  final_n = 1'b1;
                  valid_n = 1'b1;
               end
            end else if (tmo_q == TMO_W'(1)) begin
               state_n = ST_FAULT;
               err_n   = 1'b1;
            end else begin
               tmo_n = tmo_q - TMO_W'(1);
            end
         end
         ST_DONE, ST_FAULT: begin
            if (!cks_s) begin
               state_n = ST_IDLE;
               cf_n    = '0;
               final_n = 1'b0;
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         tmo_q   <= '0;
         cf_q    <= '0;
         dout_q  <= '0;
         final_q <= 1'b0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
         rdy_h   <= 1'b0;
         cks_h   <= 1'b0;
      end else begin
         state_q <= state_n;
         cnt_q   <= cnt_n;
         tmo_q   <= tmo_n;
         cf_q    <= cf_n;
         dout_q  <= dout_n;
         final_q <= final_n;
         valid_q <= valid_n;
         err_q   <= err_n;
         busy_q  <= (state_n == ST_CONV);
         rdy_h   <= rdy_s;
         cks_h   <= cks_s;
      end
   end

   assign CF    = cf_q;
   assign DOUT  = dout_q;
   assign FINAL = final_q;
   assign VALID = valid_q;
   assign BUSY  = busy_q;
   assign ERR   = err_q;

endmodule

// File: tb/tb_sar_cycle_ctrl.sv
// Directed bench for sar_cycle_ctrl: default, one-hot and short-timeout instances share stimulus.
module tb_sar_cycle_ctrl;

   logic CLK = 1'b0;
   logic RST, CKS, RDY, COMP;

   logic [7:0] cf0, dout0, cf1, dout1, cf2, dout2;
   logic       final0, valid0, busy0, err0;
   logic       final1, valid1, busy1, err1;
   logic       final2, valid2, busy2, err2;

   int n_tests = 0;
   int n_fail  = 0;
   int vcount0 = 0;

   always #5 CLK = ~CLK;

   sar_cycle_ctrl dut0 (
      .CLK(CLK), .RST(RST), .CKS(CKS), .RDY(RDY), .COMP(COMP),
      .CF(cf0), .DOUT(dout0), .FINAL(final0), .VALID(valid0), .BUSY(busy0), .ERR(err0));

   sar_cycle_ctrl #(.CF_MODE(1)) dut1 (
      .CLK(CLK), .RST(RST), .CKS(CKS), .RDY(RDY), .COMP(COMP),
      .CF(cf1), .DOUT(dout1), .FINAL(final1), .VALID(valid1), .BUSY(busy1), .ERR(err1));

   sar_cycle_ctrl #(.TIMEOUT(16)) dut2 (
      .CLK(CLK), .RST(RST), .CKS(CKS), .RDY(RDY), .COMP(COMP),
      .CF(cf2), .DOUT(dout2), .FINAL(final2), .VALID(valid2), .BUSY(busy2), .ERR(err2));

   always @(negedge CLK) if (valid0 === 1'b1) vcount0++;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic rdy_pulse(input logic c);
      @(negedge CLK) COMP = c;
      @(negedge CLK) RDY = 1'b1;
      repeat (2) @(negedge CLK);
      RDY = 1'b0;
      repeat (4) @(negedge CLK);
   endtask

   task automatic cks_start();
      @(negedge CLK) CKS = 1'b1;
      repeat (4) @(negedge CLK);
   endtask

   task automatic cks_stop();
      @(negedge CLK) CKS = 1'b0;
      repeat (4) @(negedge CLK);
   endtask

   task automatic test_reset();
      RST = 1'b1; CKS = 1'b0; RDY = 1'b0; COMP = 1'b0;
      repeat (3) @(negedge CLK);
      n_tests++; if (cf0 !== 8'h00)   begin n_fail++; $display("FAIL reset_cf got %h exp 00", cf0); end
      n_tests++; if (dout0 !== 8'h00) begin n_fail++; $display("FAIL reset_dout got %h exp 00", dout0); end
      n_tests++; if ({final0, valid0, busy0, err0} !== 4'b0000)
         begin n_fail++; $display("FAIL reset_flags got %b exp 0000", {final0, valid0, busy0, err0}); end
      RST = 1'b0;
      repeat (2) @(negedge CLK);
   endtask

   task automatic test_full_conv();
      logic [7:0] pat;
      pat = 8'b1011_0010;
      vcount0 = 0;
      cks_start();
      n_tests++; if (busy0 !== 1'b1) begin n_fail++; $display("FAIL start_busy got %b exp 1", busy0); end
      // first decision: check the update lands on edge SYNC_STAGES+1 exactly
      @(negedge CLK) COMP = pat[7];
      @(negedge CLK) RDY = 1'b1;
      repeat (2) @(negedge CLK);
      n_tests++; if (cf0 !== 8'h00) begin n_fail++; $display("FAIL latency_early_cf got %h exp 00", cf0); end
      RDY = 1'b0;
      @(negedge CLK);
      n_tests++; if (cf0 !== 8'h80) begin n_fail++; $display("FAIL latency_cf got %h exp 80", cf0); end
      n_tests++; if (dout0 !== 8'h80) begin n_fail++; $display("FAIL latency_dout got %h exp 80", dout0); end
      repeat (3) @(negedge CLK);
      for (int i = 6; i >= 0; i--) rdy_pulse(pat[i]);
      n_tests++; if (dout0 !== 8'hB2) begin n_fail++; $display("FAIL full_dout got %h exp b2", dout0); end
      n_tests++; if (cf0 !== 8'hFF)   begin n_fail++; $display("FAIL full_cf got %h exp ff", cf0); end
      n_tests++; if (final0 !== 1'b1) begin n_fail++; $display("FAIL full_final got %b exp 1", final0); end
      n_tests++; if (busy0 !== 1'b0)  begin n_fail++; $display("FAIL full_busy got %b exp 0", busy0); end
      n_tests++; if (vcount0 != 1)    begin n_fail++; $display("FAIL full_valid_count got %0d exp 1", vcount0); end
   endtask

   task automatic test_done_ignore();
      rdy_pulse(1'b0);
      n_tests++; if (dout0 !== 8'hB2) begin n_fail++; $display("FAIL done_dout got %h exp b2", dout0); end
      n_tests++; if (cf0 !== 8'hFF)   begin n_fail++; $display("FAIL done_cf got %h exp ff", cf0); end
      n_tests++; if (final0 !== 1'b1) begin n_fail++; $display("FAIL done_final got %b exp 1", final0); end
      n_tests++; if (vcount0 != 1)    begin n_fail++; $display("FAIL done_valid_count got %0d exp 1", vcount0); end
      cks_stop();
      n_tests++; if ({cf0, final0} !== 9'h000) begin n_fail++; $display("FAIL done_exit_cf_final got %h exp 000", {cf0, final0}); end
      n_tests++; if (dout0 !== 8'hB2) begin n_fail++; $display("FAIL done_exit_dout got %h exp b2", dout0); end
   endtask

   task automatic test_onehot();
      cks_start();
      rdy_pulse(1'b1); rdy_pulse(1'b0); rdy_pulse(1'b1);
      n_tests++; if (cf1 !== 8'h20)   begin n_fail++; $display("FAIL onehot_cf got %h exp 20", cf1); end
      n_tests++; if (busy1 !== 1'b1)  begin n_fail++; $display("FAIL onehot_busy got %b exp 1", busy1); end
      n_tests++; if (final1 !== 1'b0) begin n_fail++; $display("FAIL onehot_final got %b exp 0", final1); end
      n_tests++; if (cf0 !== 8'hE0)   begin n_fail++; $display("FAIL thermo3_cf got %h exp e0", cf0); end
      n_tests++; if (dout1 !== 8'hA0) begin n_fail++; $display("FAIL onehot_dout got %h exp a0", dout1); end
      cks_stop();
   endtask

   task automatic test_abort();
      vcount0 = 0;
      cks_start();
      n_tests++; if (dout0 !== 8'h00) begin n_fail++; $display("FAIL restart_dout got %h exp 00", dout0); end
      repeat (4) rdy_pulse(1'b1);
      n_tests++; if (cf0 !== 8'hF0) begin n_fail++; $display("FAIL abort_pre_cf got %h exp f0", cf0); end
      cks_stop();
      n_tests++; if (cf0 !== 8'h00)   begin n_fail++; $display("FAIL abort_cf got %h exp 00", cf0); end
      n_tests++; if (final0 !== 1'b0) begin n_fail++; $display("FAIL abort_final got %b exp 0", final0); end
      n_tests++; if (busy0 !== 1'b0)  begin n_fail++; $display("FAIL abort_busy got %b exp 0", busy0); end
      n_tests++; if (dout0 !== 8'hF0) begin n_fail++; $display("FAIL abort_dout_hold got %h exp f0", dout0); end
      n_tests++; if (vcount0 != 0)    begin n_fail++; $display("FAIL abort_valid_count got %0d exp 0", vcount0); end
      cks_start();
      n_tests++; if (dout0 !== 8'h00) begin n_fail++; $display("FAIL abort_restart_dout got %h exp 00", dout0); end
      n_tests++; if (busy0 !== 1'b1)  begin n_fail++; $display("FAIL abort_restart_busy got %b exp 1", busy0); end
      cks_stop();
   endtask

   task automatic test_timeout();
      @(negedge CLK) CKS = 1'b1;
      // CONV is entered on the 3rd edge; the fault lands 16 edges later
      repeat (18) @(negedge CLK);
      n_tests++; if (err2 !== 1'b0)  begin n_fail++; $display("FAIL tmo_early_err got %b exp 0", err2); end
      n_tests++; if (busy2 !== 1'b1) begin n_fail++; $display("FAIL tmo_early_busy got %b exp 1", busy2); end
      @(negedge CLK);
      n_tests++; if (err2 !== 1'b1)   begin n_fail++; $display("FAIL tmo_err got %b exp 1", err2); end
      n_tests++; if (busy2 !== 1'b0)  begin n_fail++; $display("FAIL tmo_busy got %b exp 0", busy2); end
      n_tests++; if (final2 !== 1'b0) begin n_fail++; $display("FAIL tmo_final got %b exp 0", final2); end
      n_tests++; if (err0 !== 1'b0)   begin n_fail++; $display("FAIL tmo_default_err got %b exp 0", err0); end
      cks_stop();
      n_tests++; if (err2 !== 1'b1) begin n_fail++; $display("FAIL tmo_sticky_err got %b exp 1", err2); end
      cks_start();
      n_tests++; if (err2 !== 1'b0) begin n_fail++; $display("FAIL tmo_clear_err got %b exp 0", err2); end
      cks_stop();
   endtask

   task automatic test_rst_mid();
      logic [7:0] pat;
      pat = 8'b0101_1101;
      vcount0 = 0;
      cks_start();
      repeat (5) rdy_pulse(1'b1);
      n_tests++; if (cf0 !== 8'hF8) begin n_fail++; $display("FAIL rst_pre_cf got %h exp f8", cf0); end
      @(negedge CLK) begin RST = 1'b1; CKS = 1'b0; end
      @(negedge CLK);
      n_tests++; if ({cf0, dout0} !== 16'h0000) begin n_fail++; $display("FAIL rst_mid_cf_dout got %h exp 0000", {cf0, dout0}); end
      n_tests++; if ({final0, valid0, busy0, err0} !== 4'b0000)
         begin n_fail++; $display("FAIL rst_mid_flags got %b exp 0000", {final0, valid0, busy0, err0}); end
      RST = 1'b0;
      repeat (2) @(negedge CLK);
      n_tests++; if (vcount0 != 0) begin n_fail++; $display("FAIL rst_mid_valid_count got %0d exp 0", vcount0); end
      cks_start();
      for (int i = 7; i >= 0; i--) rdy_pulse(pat[i]);
      n_tests++; if (dout0 !== 8'h5D) begin n_fail++; $display("FAIL rst_conv_dout got %h exp 5d", dout0); end
      n_tests++; if (cf0 !== 8'hFF)   begin n_fail++; $display("FAIL rst_conv_cf got %h exp ff", cf0); end
      n_tests++; if (final0 !== 1'b1) begin n_fail++; $display("FAIL rst_conv_final got %b exp 1", final0); end
      n_tests++; if (vcount0 != 1)    begin n_fail++; $display("FAIL rst_conv_valid_count got %0d exp 1", vcount0); end
      cks_stop();
   endtask

   initial begin
      test_reset();
      test_full_conv();
      test_done_ignore();
      test_onehot();
      test_abort();
      test_timeout();
      test_rst_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
